// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, the main
// FSM state set, and the TX sequencer's byte-select and handshake phases.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUN,
    ALU_WAIT,
    TX_LO,
    TX_HI,
    TX_RD
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LO,
    SEL_HI,
    SEL_RD
  } tx_sel_t;

  typedef enum logic [1:0] {
    TXP_IDLE,
    TXP_RISE,
    TXP_FALL
  } tx_phase_t;

endpackage

// File: rtl/sys_ctrl_if.sv
// Bus bundle between the controller and its surroundings (RX, register file,
// ALU, TX). The master modport is the controller's view.
interface sys_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);

  logic [DW-1:0]   RX_P_DATA;
  logic            RX_D_VLD;
  logic            WrEn;
  logic            RdEn;
  logic [AW-1:0]   Address;
  logic [DW-1:0]   WrData;
  logic [DW-1:0]   RdData;
  logic            Rd_D_Vid;
  logic            ALU_EN;
  logic [3:0]      ALU_FUN;
  logic [2*DW-1:0] ALU_OUT;
  logic            ALU_OUT_VLD;
  logic            CLK_GATE_EN;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD;
  logic            TX_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, Rd_D_Vid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, Rd_D_Vid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/sys_ctrl_tx.sv
// TX byte sequencer: picks the requested byte and runs one TX_BUSY
// handshake per byte, pulsing done once the busy rise-then-fall completes.
import sys_ctrl_pkg::*;

module sys_ctrl_tx #(
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  tx_sel_t         sel,
  input  logic [2*DW-1:0] alu_res,
  input  logic [DW-1:0]   rd_data,
  input  logic            busy,
  output logic [DW-1:0]   tx_data,
  output logic            tx_vld,
  output logic            done
);

  tx_phase_t     phase, phase_n;
  logic [DW-1:0] data_n, byte_sel;
  logic          vld_n;

  always_comb begin
    case (sel)
      SEL_LO:  byte_sel = alu_res[DW-1:0];
      SEL_HI:  byte_sel = alu_res[2*DW-1:DW];
      SEL_RD:  byte_sel = rd_data;
      default: byte_sel = '0;
    endcase
  end

  // The byte register only reloads on a new launch, so it stays stable
  // through the whole busy rise-then-fall of the transmitter.
  always_comb begin
    phase_n = phase;
    data_n  = tx_data;
    vld_n   = 1'b0;
    done    = 1'b0;
    case (phase)
      TXP_IDLE: if (sel != SEL_NONE && !busy) begin
        vld_n   = 1'b1;
        data_n  = byte_sel;
        phase_n = TXP_RISE;
      end
      TXP_RISE: if (busy) phase_n = TXP_FALL;
      TXP_FALL: if (!busy) begin
        done    = 1'b1;
        phase_n = TXP_IDLE;
      end
      default:  phase_n = TXP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase   <= TXP_IDLE;
      tx_data <= '0;
      tx_vld  <= 1'b0;
    end else begin
      phase   <= phase_n;
      tx_data <= data_n;
      tx_vld  <= vld_n;
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// System controller: decodes RX command bytes into register-file accesses
// and ALU operations, then returns results through the TX sequencer.
import sys_ctrl_pkg::*;

module sys_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic     CLK,
  input  logic     RST,
  sys_ctrl_if.master bus
);

  state_t          state, state_n;
  logic [AW-1:0]   wr_addr_q, wr_addr_n, address_q, address_n;
  logic [DW-1:0]   wr_data_q, wr_data_n, rd_data_q, rd_data_n;
  logic [2*DW-1:0] res_q, res_n;
  logic [3:0]      fun_q, fun_n;
  logic            wr_en_q, wr_en_n, rd_en_q, rd_en_n;
  logic            alu_en_q, alu_en_n, gate_q, gate_n;
  logic            rx_vld, tx_done;
  logic [DW-1:0]   rx_data;
  tx_sel_t         tx_sel;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_data = bus.RX_P_DATA;

  // Strobes default low so each one lasts exactly the cycle after the byte
  // that triggered it; RX strobes in wait/TX states fall through untouched.
  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr_q;
    address_n = address_q;
    wr_data_n = wr_data_q;
    rd_data_n = rd_data_q;
    res_n     = res_q;
    fun_n     = fun_q;
    gate_n    = gate_q;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    alu_en_n  = 1'b0;
    tx_sel    = SEL_NONE;
    case (state)
      IDLE: if (rx_vld) begin
        case (rx_data[7:0])
          CMD_WR:      state_n = WR_ADDR;
          CMD_RD:      state_n = RD_ADDR;
          CMD_ALU_OP:  begin state_n = OP_A;    gate_n = 1'b1; end
          CMD_ALU_NOP: begin state_n = ALU_FUN; gate_n = 1'b1; end
          default:     state_n = IDLE;
        endcase
      end
      WR_ADDR: if (rx_vld) begin
        wr_addr_n = rx_data[AW-1:0];
        state_n   = WR_DATA;
      end
      WR_DATA: if (rx_vld) begin
        wr_en_n   = 1'b1;
        address_n = wr_addr_q;
        wr_data_n = rx_data;
        state_n   = IDLE;
      end
      RD_ADDR: if (rx_vld) begin
        rd_en_n   = 1'b1;
        address_n = rx_data[AW-1:0];
        state_n   = RD_WAIT;
      end
      RD_WAIT: if (bus.Rd_D_Vid) begin
        rd_data_n = bus.RdData;
        state_n   = TX_RD;
      end
      OP_A: if (rx_vld) begin
        wr_en_n   = 1'b1;
        address_n = '0;
        wr_data_n = rx_data;
        state_n   = OP_B;
      end
      OP_B: if (rx_vld) begin
        wr_en_n   = 1'b1;
        address_n = AW'(1);
        wr_data_n = rx_data;
        state_n   = ALU_FUN;
      end
      ALU_FUN: if (rx_vld) begin
        fun_n    = rx_data[3:0];
        alu_en_n = 1'b1;
        state_n  = ALU_WAIT;
      end
      ALU_WAIT: if (bus.ALU_OUT_VLD) begin
        res_n   = bus.ALU_OUT;
        gate_n  = 1'b0;
        state_n = TX_LO;
      end
      TX_LO: begin
        tx_sel = SEL_LO;
        if (tx_done) state_n = TX_HI;
      end
      TX_HI: begin
        tx_sel = SEL_HI;
        if (tx_done) state_n = IDLE;
      end
      TX_RD: begin
        tx_sel = SEL_RD;
        if (tx_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_addr_q <= '0;
      address_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      res_q     <= '0;
      fun_q     <= '0;
      gate_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
    end else begin
      state     <= state_n;
      wr_addr_q <= wr_addr_n;
      address_q <= address_n;
      wr_data_q <= wr_data_n;
      rd_data_q <= rd_data_n;
      res_q     <= res_n;
      fun_q     <= fun_n;
      gate_q    <= gate_n;
      wr_en_q   <= wr_en_n;
      rd_en_q   <= rd_en_n;
      alu_en_q  <= alu_en_n;
    end
  end

  assign bus.WrEn        = wr_en_q;
  assign bus.RdEn        = rd_en_q;
  assign bus.Address     = address_q;
  assign bus.WrData      = wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = fun_q;
  assign bus.CLK_GATE_EN = gate_q;

  sys_ctrl_tx #(.DW(DW)) u_tx (
    .CLK     (CLK),
    .RST     (RST),
    .sel     (tx_sel),
    .alu_res (res_q),
    .rd_data (rd_data_q),
    .busy    (bus.TX_BUSY),
    .tx_data (bus.TX_P_DATA),
    .tx_vld  (bus.TX_D_VLD),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: drives command byte streams, models the
// register file, ALU and transmitter responses, and checks the strobes.
module tb_sys_ctrl;

  logic clk;
  logic rst;
  logic hold_busy;
  int   checks;
  int   errors;
  int   tx_count_down;

  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] tx_q[$];
  int         rd_cnt;
  int         alu_cnt;
  int         overlap_cnt;
  logic [3:0] rd_addr_last;
  logic [3:0] alu_fun_last;

  int w0, t0, r0, a0;

  sys_ctrl_if #(.DW(8), .AW(4)) bus ();

  sys_ctrl #(.DW(8), .AW(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Transmitter model: busy for a few cycles after each TX_D_VLD, or held
  // high by the bench to exercise back-pressure.
  initial begin
    bus.TX_BUSY   = 1'b0;
    tx_count_down = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.TX_D_VLD) tx_count_down = 3;
      else if (tx_count_down > 0) tx_count_down--;
      bus.TX_BUSY = hold_busy || (tx_count_down > 0);
    end
  end

  initial begin
    rd_cnt      = 0;
    alu_cnt     = 0;
    overlap_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.WrEn === 1'b1) begin
      wr_addr_q.push_back(bus.Address);
      wr_data_q.push_back(bus.WrData);
    end
    if (bus.RdEn === 1'b1) begin
      rd_cnt++;
      rd_addr_last = bus.Address;
    end
    if (bus.ALU_EN === 1'b1) begin
      alu_cnt++;
      alu_fun_last = bus.ALU_FUN;
    end
    if (bus.TX_D_VLD === 1'b1) tx_q.push_back(bus.TX_P_DATA);
    if (bus.WrEn === 1'b1 && bus.RdEn === 1'b1) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge clk);
    #1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
  endtask

  task automatic rf_respond(input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.RdData   = d;
    bus.Rd_D_Vid = 1'b1;
    @(posedge clk);
    #1;
    bus.Rd_D_Vid = 1'b0;
  endtask

  task automatic alu_respond(input logic [15:0] v);
    @(posedge clk);
    #1;
    bus.ALU_OUT     = v;
    bus.ALU_OUT_VLD = 1'b1;
    @(posedge clk);
    #1;
    bus.ALU_OUT_VLD = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget);
    for (int i = 0; i < budget && tx_q.size() < target; i++) @(negedge clk);
  endtask

  task automatic wait_alu(input int target, input int budget);
    for (int i = 0; i < budget && alu_cnt < target; i++) @(negedge clk);
  endtask

  task automatic wait_rd(input int target, input int budget);
    for (int i = 0; i < budget && rd_cnt < target; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_wren"},   32'(bus.WrEn),        32'h0);
    checkOutput({tag, "_rden"},   32'(bus.RdEn),        32'h0);
    checkOutput({tag, "_addr"},   32'(bus.Address),     32'h0);
    checkOutput({tag, "_wdata"},  32'(bus.WrData),      32'h0);
    checkOutput({tag, "_aluen"},  32'(bus.ALU_EN),      32'h0);
    checkOutput({tag, "_alufun"}, 32'(bus.ALU_FUN),     32'h0);
    checkOutput({tag, "_gate"},   32'(bus.CLK_GATE_EN), 32'h0);
    checkOutput({tag, "_txdata"}, 32'(bus.TX_P_DATA),   32'h0);
    checkOutput({tag, "_txvld"},  32'(bus.TX_D_VLD),    32'h0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    hold_busy       = 1'b0;
    rst             = 1'b1;
    bus.RX_P_DATA   = 8'h00;
    bus.RX_D_VLD    = 1'b0;
    bus.RdData      = 8'h00;
    bus.Rd_D_Vid    = 1'b0;
    bus.ALU_OUT     = 16'h0000;
    bus.ALU_OUT_VLD = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Register write
    w0 = wr_addr_q.size();
    r0 = rd_cnt;
    applyStimulus(8'hAA);
    applyStimulus(8'h05);
    applyStimulus(8'h3C);
    repeat (4) @(negedge clk);
    checkOutput("wr_count", 32'(wr_addr_q.size() - w0), 32'd1);
    checkOutput("wr_addr",  32'(wr_addr_q[w0]), 32'h5);
    checkOutput("wr_data",  32'(wr_data_q[w0]), 32'h3C);
    checkOutput("wr_no_rd", 32'(rd_cnt - r0), 32'd0);

    // Register read returned as a single TX byte
    r0 = rd_cnt;
    t0 = tx_q.size();
    applyStimulus(8'hBB);
    applyStimulus(8'h05);
    wait_rd(r0 + 1, 10);
    checkOutput("rd_count", 32'(rd_cnt - r0), 32'd1);
    checkOutput("rd_addr",  32'(rd_addr_last), 32'h5);
    rf_respond(8'h3C);
    wait_tx(t0 + 1, 50);
    repeat (10) @(negedge clk);
    checkOutput("rd_tx_count", 32'(tx_q.size() - t0), 32'd1);
    checkOutput("rd_tx_byte",  32'(tx_q[t0]), 32'h3C);

    // ALU with operands; a stray BB in ALU_WAIT must be dropped
    w0 = wr_addr_q.size();
    a0 = alu_cnt;
    t0 = tx_q.size();
    r0 = rd_cnt;
    applyStimulus(8'hCC);
    checkOutput("gate_on_opa", 32'(bus.CLK_GATE_EN), 32'h1);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h00);
    wait_alu(a0 + 1, 10);
    checkOutput("op_wr_count", 32'(wr_addr_q.size() - w0), 32'd2);
    checkOutput("op_a_addr",   32'(wr_addr_q[w0]), 32'h0);
    checkOutput("op_a_data",   32'(wr_data_q[w0]), 32'h12);
    checkOutput("op_b_addr",   32'(wr_addr_q[w0 + 1]), 32'h1);
    checkOutput("op_b_data",   32'(wr_data_q[w0 + 1]), 32'h34);
    checkOutput("alu_fun",     32'(alu_fun_last), 32'h0);
    applyStimulus(8'hBB);
    checkOutput("gate_in_wait", 32'(bus.CLK_GATE_EN), 32'h1);
    repeat (5) @(negedge clk);
    checkOutput("alu_en_count", 32'(alu_cnt - a0), 32'd1);
    alu_respond(16'h0046);
    wait_tx(t0 + 2, 80);
    repeat (10) @(negedge clk);
    checkOutput("alu_tx_count", 32'(tx_q.size() - t0), 32'd2);
    checkOutput("alu_tx_lo",    32'(tx_q[t0]), 32'h46);
    checkOutput("alu_tx_hi",    32'(tx_q[t0 + 1]), 32'h00);
    checkOutput("gate_off",     32'(bus.CLK_GATE_EN), 32'h0);
    checkOutput("stray_rx_drop", 32'(rd_cnt - r0), 32'd0);

    // ALU without operands under TX back-pressure
    hold_busy = 1'b1;
    a0 = alu_cnt;
    t0 = tx_q.size();
    w0 = wr_addr_q.size();
    applyStimulus(8'hDD);
    checkOutput("gate_on_fun", 32'(bus.CLK_GATE_EN), 32'h1);
    applyStimulus(8'h02);
    wait_alu(a0 + 1, 10);
    checkOutput("nop_alu_fun",  32'(alu_fun_last), 32'h2);
    checkOutput("nop_no_wr",    32'(wr_addr_q.size() - w0), 32'd0);
    alu_respond(16'hA55A);
    repeat (20) @(negedge clk);
    checkOutput("busy_hold_no_tx", 32'(tx_q.size() - t0), 32'd0);
    hold_busy = 1'b0;
    wait_tx(t0 + 2, 80);
    repeat (10) @(negedge clk);
    checkOutput("busy_tx_count", 32'(tx_q.size() - t0), 32'd2);
    checkOutput("busy_tx_lo",    32'(tx_q[t0]), 32'h5A);
    checkOutput("busy_tx_hi",    32'(tx_q[t0 + 1]), 32'hA5);

    // Unknown byte in IDLE is ignored, then a write still decodes
    w0 = wr_addr_q.size();
    r0 = rd_cnt;
    a0 = alu_cnt;
    t0 = tx_q.size();
    applyStimulus(8'h55);
    repeat (5) @(negedge clk);
    checkOutput("junk_strobes",
                32'((wr_addr_q.size() - w0) + (rd_cnt - r0) + (alu_cnt - a0) + (tx_q.size() - t0)),
                32'd0);
    checkOutput("junk_gate", 32'(bus.CLK_GATE_EN), 32'h0);
    applyStimulus(8'hAA);
    applyStimulus(8'h07);
    applyStimulus(8'h99);
    repeat (4) @(negedge clk);
    checkOutput("post_junk_wr_count", 32'(wr_addr_q.size() - w0), 32'd1);
    checkOutput("post_junk_wr_addr",  32'(wr_addr_q[w0]), 32'h7);
    checkOutput("post_junk_wr_data",  32'(wr_data_q[w0]), 32'h99);

    // Reset while waiting for the ALU aborts the command
    a0 = alu_cnt;
    applyStimulus(8'hDD);
    applyStimulus(8'h04);
    wait_alu(a0 + 1, 10);
    checkOutput("pre_rst_gate", 32'(bus.CLK_GATE_EN), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = tx_q.size();
    w0 = wr_addr_q.size();
    alu_respond(16'h1234);
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_tx",   32'(tx_q.size() - t0), 32'd0);
    checkOutput("midrst_no_wr",   32'(wr_addr_q.size() - w0), 32'd0);
    checkOutput("midrst_gate",    32'(bus.CLK_GATE_EN), 32'h0);
    checkOutput("wr_rd_overlap",  32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter DW, default 8, meaning the byte/register data width.
REQ-002 The block SHALL have parameter AW, default 4, meaning the register-file address width.

Ports:
REQ-003 CLK  in  1  the single system clock; every flop is rising-edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 RX_P_DATA  in  DW  received command/data byte.
REQ-006 RX_D_VLD  in  1  one-cycle strobe marking RX_P_DATA valid.
REQ-007 WrEn, RdEn  out  1 each  register-file write and read strobes.
REQ-008 Address  out  AW  register-file address.
REQ-009 WrData  out  DW  register-file write data.
REQ-010 RdData  in  DW  register-file read data.
REQ-011 Rd_D_Vid  in  1  register-file read-data-valid strobe.
REQ-012 ALU_EN  out  1  ALU operation enable.
REQ-013 ALU_FUN  out  4  ALU function code.
REQ-014 ALU_OUT  in  2*DW  ALU result.
REQ-015 ALU_OUT_VLD  in  1  ALU result-valid strobe.
REQ-016 CLK_GATE_EN  out  1  ALU clock-gate enable.
REQ-017 TX_P_DATA  out  DW  byte to transmit.
REQ-018 TX_D_VLD  out  1  TX data-valid strobe.
REQ-019 TX_BUSY  in  1  transmitter busy flag.

Function
REQ-020 Command bytes SHALL be: 0xAA register write (addr, data); 0xBB register read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun).
REQ-021 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD.
REQ-022 In IDLE, when RX_D_VLD=1, the FSM SHALL branch on the command byte: 0xAA to WR_ADDR, 0xBB to RD_ADDR, 0xCC to OP_A, 0xDD to ALU_FUN; any other byte is ignored and the FSM stays in IDLE.
REQ-023 Each operand state SHALL advance only on an RX_D_VLD strobe and consume exactly one byte per strobe.
REQ-024 The WR_DATA byte SHALL produce exactly one WrEn=1 cycle in the following cycle, with the latched address (low AW bits of the address byte); the FSM then returns to IDLE.
REQ-025 OP_A and OP_B SHALL each issue one WrEn pulse, to address 0 and address 1 respectively.
REQ-026 RD_ADDR SHALL issue one RdEn pulse, then wait in RD_WAIT for Rd_D_Vid, latch RdData, and go to TX_RD.
REQ-027 The ALU_FUN byte SHALL latch its low 4 bits into ALU_FUN, assert ALU_EN for exactly one cycle, then enter ALU_WAIT until ALU_OUT_VLD, latching ALU_OUT.
REQ-028 CLK_GATE_EN SHALL be 1 from entry into OP_A or ALU_FUN until ALU_OUT_VLD is seen, and 0 otherwise.
REQ-029 TX handshake: TX_D_VLD SHALL pulse for one cycle only while TX_BUSY=0, and the byte SHALL be held stable until the following TX_BUSY rise-then-fall completes.
REQ-030 The ALU result SHALL be sent low byte (TX_LO) then high byte (TX_HI); a read result SHALL be sent as one byte (TX_RD); the FSM then returns to IDLE.
REQ-031 RX_D_VLD arriving in any wait or TX state SHALL be dropped, with no state change.
REQ-032 WrEn and RdEn SHALL never be 1 in the same cycle.

Reset
REQ-033 When RST=1 at a CLK edge, the FSM SHALL enter IDLE and all outputs SHALL read 0 (WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD).
REQ-034 Reset mid-command SHALL abort the command with no further strobes.

Structure
REQ-035 Command opcodes and the state enumeration SHALL live in the shared package sys_ctrl_pkg.
REQ-036 The TX byte sequencer (low/high/single byte plus the TX_BUSY handshake) SHALL be one sub-module, sys_ctrl_tx.

Verification
REQ-037 Write: RX bytes AA,05,3C -> one WrEn cycle with Address=5, WrData=0x3C.
REQ-038 Read: RX BB,05; RdData=0x3C with Rd_D_Vid -> TX_P_DATA=0x3C, one TX_D_VLD pulse.
REQ-039 ALU: RX CC,12,34,00; ALU_OUT=0x0046 -> WrEn at addresses 0 and 1, ALU_EN for 1 cycle, TX bytes 46 then 00.
REQ-040 DD,02 with TX_BUSY=1 held for 20 cycles -> TX_D_VLD stays 0 until TX_BUSY=0.
REQ-041 RX byte 0x55 in IDLE -> no strobes; RST asserted during ALU_WAIT -> IDLE with all outputs 0.
